// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch redirect controller:
// branch-type codes, FSM state encoding and the default PC width.
package branch_pkg;

    localparam int PC_W_DEF = 10;

    localparam logic [3:0] BR_NONE  = 4'd0;
    localparam logic [3:0] BR_BRCC  = 4'd1;
    localparam logic [3:0] BR_BRCS  = 4'd2;
    localparam logic [3:0] BR_BREQ  = 4'd3;
    localparam logic [3:0] BR_BRN   = 4'd4;
    localparam logic [3:0] BR_BRNE  = 4'd5;
    localparam logic [3:0] BR_CALL  = 4'd6;
    localparam logic [3:0] BR_RET   = 4'd7;
    localparam logic [3:0] BR_RETID = 4'd8;
    localparam logic [3:0] BR_RETIE = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    function automatic logic br_taken(input logic [3:0] t, input logic c, input logic z);
        logic tk;
        case (t)
            BR_BRCC:  tk = ~c;
            BR_BRCS:  tk = c;
            BR_BREQ:  tk = z;
            BR_BRNE:  tk = ~z;
            BR_BRN, BR_CALL, BR_RET, BR_RETID, BR_RETIE: tk = 1'b1;
            default:  tk = 1'b0;
        endcase
        return tk;
    endfunction

    function automatic logic br_is_return(input logic [3:0] t);
        return (t == BR_RET) || (t == BR_RETID) || (t == BR_RETIE);
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_ras.sv
// Return-address stack: circular buffer; a push when full overwrites the
// oldest entry, a pop when empty leaves the pointer alone.
module branch_ras #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         ovf_o,
    output logic         unf_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             full;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == CNT_MAX);
    assign top_o   = mem_q[ptr_q - PTR_ONE];
    assign ovf_o   = push_i & full;
    assign unf_o   = pop_i & ~push_i & empty_o;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_ONE;
            if (!full) cnt_d = cnt_q + CNT_ONE;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: emptiness is tracked by cnt_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch resolution, PC redirect and IF/ID squash sequencing.
// Optional taken/flush statistics counters enabled by `define BRANCH_STATS_EN.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int RAS_DEPTH    = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic [3:0]      ex_branch_type_i,
    input  logic            ex_c_i,
    input  logic            ex_z_i,
    input  logic [PC_W-1:0] ex_pc_i,
    input  logic [PC_W-1:0] ex_target_i,
    output logic            pc_load_o,
    output logic [PC_W-1:0] pc_next_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            i_set_o,
    output logic            i_clr_o,
    output logic            ras_ovf_o,
    output logic            ras_unf_o,
    output logic [15:0]     taken_count_o,
    output logic [15:0]     flush_count_o
);
    localparam logic [PC_W-1:0] PC_ONE     = 1;
    localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e          state_q;
    logic [2:0]      cnt_q;
    logic            pc_load_q;
    logic            flush_q;
    logic [PC_W-1:0] target_q, target_d;
    logic            iset_pend_q, iclr_pend_q;
    logic            ovf_q, unf_q;

    logic            taken, is_ret, push, pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty, ras_ovf, ras_unf;

    // Branches resolve only in IDLE; wrong-path instructions during a flush are ignored.
    assign taken  = (state_q == ST_IDLE) && ex_valid_i && !stall_i
                    && br_taken(ex_branch_type_i, ex_c_i, ex_z_i);
    assign is_ret = br_is_return(ex_branch_type_i);
    assign push   = taken && (ex_branch_type_i == BR_CALL);
    assign pop    = taken && is_ret;

    always_comb begin
        target_d = ex_target_i;
        if (is_ret && !ras_empty) target_d = ras_top;
    end

    branch_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (ex_pc_i + PC_ONE),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .ovf_o       (ras_ovf),
        .unf_o       (ras_unf)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pc_load_q   <= 1'b0;
            flush_q     <= 1'b0;
            target_q    <= '0;
            iset_pend_q <= 1'b0;
            iclr_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (!stall_i) begin
            if (ras_ovf) ovf_q <= 1'b1;
            if (ras_unf) unf_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (taken) begin
                        state_q     <= ST_REDIRECT;
                        pc_load_q   <= 1'b1;
                        flush_q     <= 1'b1;
                        target_q    <= target_d;
                        iset_pend_q <= (ex_branch_type_i == BR_RETIE);
                        iclr_pend_q <= (ex_branch_type_i == BR_RETID);
                    end
                end
                ST_REDIRECT: begin
                    pc_load_q   <= 1'b0;
                    iset_pend_q <= 1'b0;
                    iclr_pend_q <= 1'b0;
                    if (FLUSH_CYCLES <= 1) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q <= 3'd1) begin
                        state_q <= ST_IDLE;
                        flush_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pc_load_q <= 1'b0;
                    flush_q   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_load_o  = pc_load_q;
    assign pc_next_o  = target_q;
    assign flush_if_o = flush_q;
    assign flush_id_o = flush_q;
    assign ras_ovf_o  = ovf_q;
    assign ras_unf_o  = unf_q;
    // Interrupt-flag pulses fire on the first REDIRECT cycle that is not stalled.
    assign i_set_o    = iset_pend_q & ~stall_i;
    assign i_clr_o    = iclr_pend_q & ~stall_i;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            taken_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!stall_i) begin
            if (taken && taken_cnt_q != 16'hFFFF) taken_cnt_q <= taken_cnt_q + 16'd1;
            if (flush_q && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign taken_count_o = taken_cnt_q;
    assign flush_count_o = flush_cnt_q;
`else
    assign taken_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized and directed bench for branch_redirect_ctrl against a
// cycle-level reference model (remaining-flush countdown plus queue RAS).
module tb_branch_redirect_ctrl;
    localparam int PC_W         = 10;
    localparam int RAS_DEPTH    = 8;
    localparam int FLUSH_CYCLES = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall;
    logic            ex_valid;
    logic [3:0]      ex_type;
    logic            ex_c, ex_z;
    logic [PC_W-1:0] ex_pc, ex_target;
    logic            pc_load, flush_if, flush_id, i_set, i_clr, ras_ovf, ras_unf;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     taken_count, flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int              m_left;
    bit              m_first;
    bit              m_iset, m_iclr;
    logic [PC_W-1:0] m_pc_next;
    logic [PC_W-1:0] m_ras[$];
    bit              m_ovf, m_unf;
    int              m_taken_cnt, m_flush_cnt;

    branch_redirect_ctrl #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .stall_i          (stall),
        .ex_valid_i       (ex_valid),
        .ex_branch_type_i (ex_type),
        .ex_c_i           (ex_c),
        .ex_z_i           (ex_z),
        .ex_pc_i          (ex_pc),
        .ex_target_i      (ex_target),
        .pc_load_o        (pc_load),
        .pc_next_o        (pc_next),
        .flush_if_o       (flush_if),
        .flush_id_o       (flush_id),
        .i_set_o          (i_set),
        .i_clr_o          (i_clr),
        .ras_ovf_o        (ras_ovf),
        .ras_unf_o        (ras_unf),
        .taken_count_o    (taken_count),
        .flush_count_o    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_is_taken(input int t, input bit c, input bit z);
        case (t)
            1: return !c;
            2: return c;
            3: return z;
            5: return !z;
            4, 6, 7, 8, 9: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_left = 0; m_first = 0; m_iset = 0; m_iclr = 0;
        m_pc_next = '0;
        m_ras.delete();
        m_ovf = 0; m_unf = 0;
        m_taken_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic model_update(input bit v, input int t, input bit c, input bit z,
                                input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tg, input bit st);
        if (st) return;
        if (m_left > 0) begin
            if (m_flush_cnt < 65535) m_flush_cnt++;
            m_left--;
            m_first = 0;
            m_iset  = 0;
            m_iclr  = 0;
        end else if (v && m_is_taken(t, c, z)) begin
            if (t == 6) begin
                m_ras.push_back(pc + 1'b1);
                if (m_ras.size() > RAS_DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                m_pc_next = tg;
            end else if (t >= 7 && t <= 9) begin
                if (m_ras.size() == 0) begin
                    m_pc_next = tg;
                    m_unf = 1;
                end else begin
                    m_pc_next = m_ras.pop_back();
                end
            end else begin
                m_pc_next = tg;
            end
            m_left  = FLUSH_CYCLES;
            m_first = 1;
            m_iset  = (t == 9);
            m_iclr  = (t == 8);
            if (m_taken_cnt < 65535) m_taken_cnt++;
        end
    endtask

    task automatic check_outputs();
        check_eq("pc_load",  pc_load,  (m_left > 0) && m_first);
        check_eq("flush_if", flush_if, m_left > 0);
        check_eq("flush_id", flush_id, m_left > 0);
        check_eq("pc_next",  pc_next,  m_pc_next);
        check_eq("i_set",    i_set,    m_first && m_iset && !stall);
        check_eq("i_clr",    i_clr,    m_first && m_iclr && !stall);
        check_eq("ras_ovf",  ras_ovf,  m_ovf);
        check_eq("ras_unf",  ras_unf,  m_unf);
`ifdef BRANCH_STATS_EN
        check_eq("taken_cnt", taken_count, m_taken_cnt);
        check_eq("flush_cnt", flush_count, m_flush_cnt);
`else
        check_eq("taken_cnt", taken_count, 0);
        check_eq("flush_cnt", flush_count, 0);
`endif
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step(input bit v, input logic [3:0] t, input bit c, input bit z,
                        input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tg, input bit st);
        ex_valid = v; ex_type = t; ex_c = c; ex_z = z;
        ex_pc = pc; ex_target = tg; stall = st;
        #1;
        check_outputs();
        model_update(v, int'(t), c, z, pc, tg, st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // A taken branch followed by its flush window, during which a BRN is presented and must be ignored.
    task automatic branch(input logic [3:0] t, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tg);
        step(1'b1, t, 1'b0, 1'b0, pc, tg, 1'b0);
        for (int i = 0; i < FLUSH_CYCLES; i++)
            step(1'b1, 4'd4, 1'b0, 1'b0, 10'h2AA, 10'h155, 1'b0);
    endtask

    task automatic do_reset();
        ex_valid = 1'b0; stall = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_type = '0;
        ex_c = 1'b0; ex_z = 1'b0; ex_pc = '0; ex_target = '0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // BRNE taken with Z=0
        step(1'b1, 4'd5, 1'b0, 1'b0, 10'h010, 10'h040, 1'b0);
        check_eq("brne_pc_load", pc_load, 1);
        check_eq("brne_target", pc_next, 10'h040);
        idle(); idle(); idle();

        // Not-taken cases
        step(1'b1, 4'd3, 1'b0, 1'b0, 10'h011, 10'h0AA, 1'b0);
        step(1'b1, 4'd2, 1'b0, 1'b1, 10'h012, 10'h0BB, 1'b0);
        step(1'b1, 4'hB, 1'b1, 1'b1, 10'h013, 10'h0CC, 1'b0);
        check_eq("not_taken_flush", flush_if, 0);
        idle();

        // CALL / RET / RET with underflow
        branch(4'd6, 10'h020, 10'h100);
        branch(4'd7, 10'h100, 10'h3FF);
        check_eq("ret_from_ras", pc_next, 10'h021);
        check_eq("ret_no_unf", ras_unf, 0);
        branch(4'd7, 10'h101, 10'h3FF);
        check_eq("ret_underflow_tgt", pc_next, 10'h3FF);
        check_eq("ret_underflow_flag", ras_unf, 1);

        // RAS overflow and LIFO order
        do_reset();
        for (int i = 0; i < 9; i++) branch(4'd6, 10'(10'h100 + i * 4), 10'h200);
        check_eq("ras_ovf_set", ras_ovf, 1);
        for (int k = 0; k < 8; k++) begin
            branch(4'd7, 10'h300, 10'h3FF);
            check_eq("ras_lifo", pc_next, 10'(10'h100 + (8 - k) * 4 + 1));
        end
        check_eq("ras_lifo_no_unf", ras_unf, 0);

        // RETIE with stall held over the redirect cycle
        branch(4'd6, 10'h050, 10'h000);
        step(1'b1, 4'd9, 1'b0, 1'b0, 10'h060, 10'h000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd4, 1'b0, 1'b0, 10'h070, 10'h080, 1'b1);
            check_eq("stall_hold_pc_load", pc_load, 1);
        end
        step(1'b1, 4'd4, 1'b0, 1'b0, 10'h070, 10'h080, 1'b0);
        step(1'b1, 4'd4, 1'b0, 1'b0, 10'h070, 10'h080, 1'b0);
        check_eq("retie_target", pc_next, 10'h051);
        idle();

        // Reset mid-flush, then RET falls back to EX_TARGET
        step(1'b1, 4'd6, 1'b0, 1'b0, 10'h0F0, 10'h111, 1'b0);
        idle();
        do_reset();
        check_eq("reset_flush", flush_if, 0);
        branch(4'd7, 10'h000, 10'h155);
        check_eq("ret_after_reset", pc_next, 10'h155);
        check_eq("unf_after_reset", ras_unf, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] t;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 1) == 0) t = 4'($urandom_range(6, 9));
                else t = 4'($urandom_range(0, 15));
                step(($urandom_range(0, 3) != 0), t, 1'($urandom), 1'($urandom),
                     10'($urandom), 10'($urandom), ($urandom_range(0, 4) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
